version_writer: RTL and testbench
=================================

VERSION_WRITER -- requirements
Module: version_writer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of one stored data word.
REQ-002 SHALL have parameter VERSION_WIDTH, default 4, width of one version tag.
REQ-003 SHALL have parameter VERSION_NUM, default 4, number of version slots; SLOT_WIDTH = max(1, ceil(log2(VERSION_NUM))) is derived.
REQ-004 SHALL have one clock; reset is asynchronous and active-low: ports clk (input, 1, rising-edge clock) and rstN (input, 1, async active-low reset).
REQ-005 SHALL have wrValid  input  1  write request present.
REQ-006 SHALL have wrReady  output  1  block can accept a request.
REQ-007 SHALL have wrData  input  DATA_WIDTH  data to store.
REQ-008 SHALL have wrVersion  input  VERSION_WIDTH  version tag of wrData.
REQ-009 SHALL have clear  input  1  synchronous flush of all slots.
REQ-010 SHALL have dataInputs  output  DATA_WIDTH*VERSION_NUM  slot k data at bits [k*DATA_WIDTH +: DATA_WIDTH], feeds priorityRouter dataInputs.
REQ-011 SHALL have versions  output  VERSION_WIDTH*VERSION_NUM  slot k tag at [k*VERSION_WIDTH +: VERSION_WIDTH], feeds priorityRouter versions.
REQ-012 SHALL have slotValid  output  VERSION_NUM  bit k high when slot k holds a committed write.
REQ-013 SHALL have wrDone  output  1  one-cycle pulse, write committed.
REQ-014 SHALL have wrSlot  output  SLOT_WIDTH  slot written, valid while wrDone high.
REQ-015 SHALL have wrEvict  output  1  committed write replaced a valid slot of a different version, valid while wrDone high.

Function
REQ-016 SHALL implement FSM states IDLE, LOOKUP, COMMIT; wrReady = 1 only in IDLE.
REQ-017 IDLE: on wrValid && wrReady at a rising edge SHALL capture wrData/wrVersion into holding registers and go to LOOKUP; otherwise stay.
REQ-018 LOOKUP: SHALL select target slot, register it, go to COMMIT unconditionally.
REQ-019 Target selection priority: (1) valid slot whose tag equals captured version (hit, overwrite in place); (2) lowest-index invalid slot; (3) slot at evictPtr (eviction).
REQ-020 COMMIT: at the next edge SHALL write data and tag into the target slot, set its slotValid bit, return to IDLE.
REQ-021 wrDone, wrSlot, wrEvict SHALL be registered and high/valid for exactly the first IDLE cycle after COMMIT, coincident with the updated slot outputs; wrSlot and wrEvict SHALL be 0 whenever wrDone is 0.
REQ-022 Latency: request accepted at edge N -> slot outputs and wrDone change at edge N+2; maximum throughput one write per 3 cycles.
REQ-023 evictPtr (SLOT_WIDTH bits) SHALL advance by one only on an eviction commit, wrapping VERSION_NUM-1 -> 0; hits and free-slot fills leave it unchanged.
REQ-024 At most one valid slot SHALL hold any given tag (invariant guaranteed by REQ-019).
REQ-025 wrData/wrVersion changes while wrReady is 0 SHALL have no effect.
REQ-026 clear SHALL take priority over all activity in every state: at the edge, all slotValid, dataInputs, versions, evictPtr go to 0, FSM to IDLE, any in-flight write is discarded, and no wrDone is issued for it.
REQ-027 clear and wrValid together in IDLE SHALL flush and not accept the request.

Reset
REQ-028 rstN low SHALL immediately, independent of clk, force FSM to IDLE, all dataInputs, versions, slotValid, evictPtr, wrDone, wrSlot, wrEvict and holding registers to 0.
REQ-029 Reset asserted mid-write SHALL abandon the write; wrReady SHALL read 1 in the first cycle after rstN rises.

Verification
REQ-030 Fill: after reset, write (0x11,v1),(0x22,v2),(0x33,v3),(0x44,v4) -> slots 0..3, slotValid=4'b1111, wrEvict=0 each, wrDone 2 edges after each accept.
REQ-031 Hit: then write (0xAA,v2) -> wrSlot=1, wrEvict=0, slot1 data 0xAA, evictPtr unchanged at 0.
REQ-032 Eviction wrap: then write versions 5,6,7,8,9 -> wrSlot 0,1,2,3,0, wrEvict=1 each, evictPtr ends at 1.
REQ-033 Clear mid-write: accept (0x55,v7), assert clear during LOOKUP -> no wrDone, slotValid=0, all outputs 0, wrReady=1 next cycle.
REQ-034 Async reset: drop rstN between clock edges during COMMIT -> outputs 0 before next edge; router fed from outputs returns no valid match for any readVersion.
REQ-035 Backpressure: hold wrValid high for 9 cycles with constant (0x77,v3) -> exactly 3 accepts, all hits on same slot after the first.

Source files
------------

// File: rtl/version_writer.sv
// Versioned slot writer: captures a tagged write, picks a slot (hit, free, or round-robin
// eviction) and commits it two edges after acceptance, feeding a downstream priority router.
module version_writer #(
    parameter int DATA_WIDTH    = 32,
    parameter int VERSION_WIDTH = 4,
    parameter int VERSION_NUM   = 4,
    localparam int SLOT_WIDTH   = (VERSION_NUM > 1) ? $clog2(VERSION_NUM) : 1
) (
    input  logic                               clk,
    input  logic                               rstN,
    input  logic                               wrValid,
    output logic                               wrReady,
    input  logic [DATA_WIDTH-1:0]              wrData,
    input  logic [VERSION_WIDTH-1:0]           wrVersion,
    input  logic                               clear,
    output logic [DATA_WIDTH*VERSION_NUM-1:0]  dataInputs,
    output logic [VERSION_WIDTH*VERSION_NUM-1:0] versions,
    output logic [VERSION_NUM-1:0]             slotValid,
    output logic                               wrDone,
    output logic [SLOT_WIDTH-1:0]              wrSlot,
    output logic                               wrEvict
);

    // state  | meaning
    // IDLE   | ready, waiting for a request
    // LOOKUP | choose target slot for the held write
    // COMMIT | write held data/tag into the target slot
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOOKUP = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    logic [1:0]               state_q, state_d;
    logic [DATA_WIDTH-1:0]    data_hold_q, data_hold_d;
    logic [VERSION_WIDTH-1:0] ver_hold_q, ver_hold_d;
    logic [SLOT_WIDTH-1:0]    tgt_q, tgt_d;
    logic                     tgt_evict_q, tgt_evict_d;
    logic [DATA_WIDTH-1:0]    data_q [VERSION_NUM];
    logic [DATA_WIDTH-1:0]    data_d [VERSION_NUM];
    logic [VERSION_WIDTH-1:0] tag_q [VERSION_NUM];
    logic [VERSION_WIDTH-1:0] tag_d [VERSION_NUM];
    logic [VERSION_NUM-1:0]   valid_q, valid_d;
    logic [SLOT_WIDTH-1:0]    evict_ptr_q, evict_ptr_d;
    logic                     done_q, done_d;
    logic [SLOT_WIDTH-1:0]    done_slot_q, done_slot_d;
    logic                     done_evict_q, done_evict_d;

    logic                     hit_found, free_found;
    logic [SLOT_WIDTH-1:0]    hit_slot, free_slot;

    // Lowest-index match wins for both searches; tag uniqueness makes the hit unique anyway.
    always_comb begin
        hit_found  = 1'b0;
        hit_slot   = '0;
        free_found = 1'b0;
        free_slot  = '0;
        for (int k = 0; k < VERSION_NUM; k++) begin
            if (valid_q[k] && (tag_q[k] == ver_hold_q) && !hit_found) begin
                hit_found = 1'b1;
                hit_slot  = SLOT_WIDTH'(k);
            end
            if (!valid_q[k] && !free_found) begin
                free_found = 1'b1;
                free_slot  = SLOT_WIDTH'(k);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        data_hold_d  = data_hold_q;
        ver_hold_d   = ver_hold_q;
        tgt_d        = tgt_q;
        tgt_evict_d  = tgt_evict_q;
        data_d       = data_q;
        tag_d        = tag_q;
        valid_d      = valid_q;
        evict_ptr_d  = evict_ptr_q;
        done_d       = 1'b0;
        done_slot_d  = '0;
        done_evict_d = 1'b0;
        if (clear) begin
            state_d     = ST_IDLE;
            data_hold_d = '0;
            ver_hold_d  = '0;
            tgt_d       = '0;
            tgt_evict_d = 1'b0;
            valid_d     = '0;
            evict_ptr_d = '0;
            for (int k = 0; k < VERSION_NUM; k++) begin
                data_d[k] = '0;
                tag_d[k]  = '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (wrValid) begin
                        data_hold_d = wrData;
                        ver_hold_d  = wrVersion;
                        state_d     = ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (hit_found) begin
                        tgt_d       = hit_slot;
                        tgt_evict_d = 1'b0;
                    end else if (free_found) begin
                        tgt_d       = free_slot;
                        tgt_evict_d = 1'b0;
                    end else begin
                        tgt_d       = evict_ptr_q;
                        tgt_evict_d = 1'b1;
                    end
                    state_d = ST_COMMIT;
                end
                ST_COMMIT: begin
                    data_d[tgt_q]  = data_hold_q;
                    tag_d[tgt_q]   = ver_hold_q;
                    valid_d[tgt_q] = 1'b1;
                    done_d         = 1'b1;
                    done_slot_d    = tgt_q;
                    done_evict_d   = tgt_evict_q;
                    if (tgt_evict_q) begin
                        evict_ptr_d = (evict_ptr_q == SLOT_WIDTH'(VERSION_NUM - 1)) ?
                                      '0 : evict_ptr_q + SLOT_WIDTH'(1);
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q      <= ST_IDLE;
            data_hold_q  <= '0;
            ver_hold_q   <= '0;
            tgt_q        <= '0;
            tgt_evict_q  <= 1'b0;
            valid_q      <= '0;
            evict_ptr_q  <= '0;
            done_q       <= 1'b0;
            done_slot_q  <= '0;
            done_evict_q <= 1'b0;
            for (int k = 0; k < VERSION_NUM; k++) begin
                data_q[k] <= '0;
                tag_q[k]  <= '0;
            end
        end else begin
            state_q      <= state_d;
            data_hold_q  <= data_hold_d;
            ver_hold_q   <= ver_hold_d;
            tgt_q        <= tgt_d;
            tgt_evict_q  <= tgt_evict_d;
            valid_q      <= valid_d;
            evict_ptr_q  <= evict_ptr_d;
            done_q       <= done_d;
            done_slot_q  <= done_slot_d;
            done_evict_q <= done_evict_d;
            for (int k = 0; k < VERSION_NUM; k++) begin
                data_q[k] <= data_d[k];
                tag_q[k]  <= tag_d[k];
            end
        end
    end

    always_comb begin
        dataInputs = '0;
        versions   = '0;
        for (int k = 0; k < VERSION_NUM; k++) begin
            dataInputs[k*DATA_WIDTH +: DATA_WIDTH]       = data_q[k];
            versions[k*VERSION_WIDTH +: VERSION_WIDTH]   = tag_q[k];
        end
    end

    assign wrReady   = (state_q == ST_IDLE);
    assign slotValid = valid_q;
    assign wrDone    = done_q;
    assign wrSlot    = done_slot_q;
    assign wrEvict   = done_evict_q;

endmodule

// File: tb/tb_version_writer.sv
// Directed bench for version_writer: table-driven fill/hit/eviction writes plus
// hand-written clear, async-reset and backpressure sequences.
module tb_version_writer;

    logic         clk;
    logic         rstN;
    logic         wrValid;
    logic         wrReady;
    logic [31:0]  wrData;
    logic [3:0]   wrVersion;
    logic         clear;
    logic [127:0] dataInputs;
    logic [15:0]  versions;
    logic [3:0]   slotValid;
    logic         wrDone;
    logic [1:0]   wrSlot;
    logic         wrEvict;

    int total = 0;
    int bad   = 0;

    version_writer #(.DATA_WIDTH(32), .VERSION_WIDTH(4), .VERSION_NUM(4)) dut (
        .clk        (clk),
        .rstN       (rstN),
        .wrValid    (wrValid),
        .wrReady    (wrReady),
        .wrData     (wrData),
        .wrVersion  (wrVersion),
        .clear      (clear),
        .dataInputs (dataInputs),
        .versions   (versions),
        .slotValid  (slotValid),
        .wrDone     (wrDone),
        .wrSlot     (wrSlot),
        .wrEvict    (wrEvict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  ver;
        logic [1:0]  slot;
        logic        evict;
        logic [3:0]  valid;
        logic [1:0]  ptr;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept at edge N, commit visible just after edge N+2.
    task automatic do_write(input vec_t v);
        wrValid   = 1'b1;
        wrData    = v.data;
        wrVersion = v.ver;
        tick();
        wrValid   = 1'b0;
        wrData    = 32'hDEAD_BEEF;
        wrVersion = ~v.ver;
        check("ready_low_after_accept", wrReady, 1'b0);
        tick();
        check("no_done_at_n1", wrDone, 1'b0);
        tick();
        check("done_at_n2", wrDone, 1'b1);
        check("wr_slot", wrSlot, v.slot);
        check("wr_evict", wrEvict, v.evict);
        check("slot_data", dataInputs[v.slot*32 +: 32], v.data);
        check("slot_tag", versions[v.slot*4 +: 4], v.ver);
        check("slot_valid", slotValid, v.valid);
        check("evict_ptr", dut.evict_ptr_q, v.ptr);
        check("ready_after_commit", wrReady, 1'b1);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc, dones, match;
        vecs[0] = '{32'h11, 4'd1, 2'd0, 1'b0, 4'b0001, 2'd0};
        vecs[1] = '{32'h22, 4'd2, 2'd1, 1'b0, 4'b0011, 2'd0};
        vecs[2] = '{32'h33, 4'd3, 2'd2, 1'b0, 4'b0111, 2'd0};
        vecs[3] = '{32'h44, 4'd4, 2'd3, 1'b0, 4'b1111, 2'd0};
        vecs[4] = '{32'hAA, 4'd2, 2'd1, 1'b0, 4'b1111, 2'd0};
        vecs[5] = '{32'hE5, 4'd5, 2'd0, 1'b1, 4'b1111, 2'd1};
        vecs[6] = '{32'hE6, 4'd6, 2'd1, 1'b1, 4'b1111, 2'd2};
        vecs[7] = '{32'hE7, 4'd7, 2'd2, 1'b1, 4'b1111, 2'd3};
        vecs[8] = '{32'hE8, 4'd8, 2'd3, 1'b1, 4'b1111, 2'd0};
        vecs[9] = '{32'hE9, 4'd9, 2'd0, 1'b1, 4'b1111, 2'd1};

        rstN = 1'b0; wrValid = 1'b0; wrData = '0; wrVersion = '0; clear = 1'b0;
        #23 rstN = 1'b1;
        tick();
        check("rst_ready", wrReady, 1'b1);
        check("rst_valid", slotValid, 4'b0000);
        check("rst_data", dataInputs, 128'h0);
        check("rst_versions", versions, 16'h0);
        check("rst_done", {wrDone, wrSlot, wrEvict}, 4'h0);

        for (int i = 0; i < 10; i++) do_write(vecs[i]);
        check("final_slot1_data", dataInputs[63:32], 32'hE6);
        check("final_versions", versions, 16'h8769);

        // Clear during LOOKUP discards the in-flight write.
        wrValid = 1'b1; wrData = 32'h55; wrVersion = 4'd7;
        tick();
        wrValid = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_valid", slotValid, 4'b0000);
        check("clr_data", dataInputs, 128'h0);
        check("clr_versions", versions, 16'h0);
        check("clr_ready", wrReady, 1'b1);
        check("clr_done", wrDone, 1'b0);
        check("clr_ptr", dut.evict_ptr_q, 2'd0);
        tick();
        check("clr_no_late_done", wrDone, 1'b0);

        // Async reset during COMMIT.
        do_write('{32'h12, 4'd1, 2'd0, 1'b0, 4'b0001, 2'd0});
        wrValid = 1'b1; wrData = 32'h99; wrVersion = 4'd2;
        tick();
        wrValid = 1'b0;
        tick();
        #2 rstN = 1'b0;
        #1;
        check("arst_valid", slotValid, 4'b0000);
        check("arst_data", dataInputs, 128'h0);
        check("arst_versions", versions, 16'h0);
        check("arst_done", {wrDone, wrSlot, wrEvict}, 4'h0);
        match = 0;
        for (int rv = 0; rv < 16; rv++)
            for (int k = 0; k < 4; k++)
                if (slotValid[k] && versions[k*4 +: 4] == 4'(rv)) match++;
        check("arst_router_no_match", match, 0);
        #2 rstN = 1'b1;
        tick();
        check("arst_ready", wrReady, 1'b1);
        check("arst_no_done", wrDone, 1'b0);

        // Backpressure: 9 edges of constant request.
        acc = 0; dones = 0;
        wrValid = 1'b1; wrData = 32'h77; wrVersion = 4'd3;
        for (int i = 0; i < 9; i++) begin
            if (wrReady) acc++;
            tick();
            if (wrDone) begin
                dones++;
                check("bp_slot", wrSlot, 2'd0);
                check("bp_evict", wrEvict, 1'b0);
            end
        end
        wrValid = 1'b0;
        check("bp_accepts", acc, 3);
        check("bp_dones", dones, 3);
        check("bp_valid", slotValid, 4'b0001);
        check("bp_data", dataInputs[31:0], 32'h77);
        check("bp_ptr", dut.evict_ptr_q, 2'd0);
        tick();
        check("bp_done_clears", wrDone, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
